// File: rtl/mm_pkg.sv
// Shared types and width helpers for the banked stream-to-matrix loader.
package mm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } state_e;

    // Elements carried by one stream beat.
    function automatic int unsigned epb_f(input int unsigned s_w, input int unsigned d_w);
        return s_w / d_w;
    endfunction

    // Address width for a given depth, never narrower than one bit.
    function automatic int unsigned addr_w_f(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bank_ram.sv
// Single-clock bank RAM: one write port, one registered read port.
module bank_ram
    import mm_pkg::*;
#(
    parameter int unsigned  D_W   = 8,
    parameter int unsigned  DEPTH = 16,
    localparam int unsigned AW    = addr_w_f(DEPTH)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           we_i,
    input  logic [AW-1:0]  waddr_i,
    input  logic [D_W-1:0] wdata_i,
    input  logic           re_i,
    input  logic [AW-1:0]  raddr_i,
    output logic [D_W-1:0] rdata_o
);

    logic [D_W-1:0] mem_q [DEPTH];
    logic [D_W-1:0] rdata_q;

    // Storage array: written one element at a time, contents not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register: updates only on a read strobe, otherwise holds.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/s2mm_banked_loader.sv
// Unpacks an AXI-stream frame of two MxM matrices into N1 A banks and N2 B
// banks, one element per cycle, then serves parallel reads until released.
module s2mm_banked_loader
    import mm_pkg::*;
#(
    parameter int unsigned  M     = 8,
    parameter int unsigned  N1    = 4,
    parameter int unsigned  N2    = 4,
    parameter int unsigned  D_W   = 8,
    parameter int unsigned  S_W   = 32,
    parameter int unsigned  CNT_W = 16,
    localparam int unsigned AW_A  = addr_w_f(M*M/N1),
    localparam int unsigned AW_B  = addr_w_f(M*M/N2)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [S_W-1:0]         s_axis_s2mm_tdata,
    input  logic [S_W/8-1:0]       s_axis_s2mm_tkeep,
    input  logic                   s_axis_s2mm_tlast,
    input  logic                   s_axis_s2mm_tvalid,
    output logic                   s_axis_s2mm_tready,
    input  logic                   rd_en,
    input  logic [AW_A-1:0]        rd_addr_A,
    input  logic [AW_B-1:0]        rd_addr_B,
    output logic [N1-1:0][D_W-1:0] A_bram,
    output logic [N2-1:0][D_W-1:0] B_bram,
    output logic                   rd_valid,
    input  logic                   release_buf,
    output logic                   full,
    output logic                   err_tlast,
    output logic [CNT_W-1:0]       frames_loaded
);

    localparam int unsigned EPB = epb_f(S_W, D_W);
    localparam int unsigned DA  = M*M/N1;
    localparam int unsigned DB  = M*M/N2;
    localparam int unsigned TOT = 2*M*M;
    localparam int unsigned EW  = $clog2(TOT);
    localparam int unsigned IW  = addr_w_f(EPB);

    localparam logic [EW-1:0] E_LAST = EW'(TOT - 1);
    localparam logic [EW-1:0] E_MM   = EW'(M*M);
    localparam logic [IW-1:0] I_LAST = IW'(EPB - 1);

    state_e           state_q, state_d;
    logic [EW-1:0]    e_q, e_d;
    logic [S_W-1:0]   buf_q, buf_d;
    logic             vld_q, vld_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy_en_q;
    logic             rd_valid_q;

    logic             wr_act, frame_end, abort, tready, beat_acc, rd_fire;
    logic [D_W-1:0]   wr_data;
    logic [D_W-1:0]   elems [EPB];
    logic             is_a;
    logic [EW-1:0]    eb_off, a_bank, b_bank;
    logic [AW_A-1:0]  a_addr;
    logic [AW_B-1:0]  b_addr;

    logic unused_keep;
    assign unused_keep = ^s_axis_s2mm_tkeep;

    for (genvar k = 0; k < EPB; k++) begin : g_unpack
        assign elems[k] = buf_q[k*D_W +: D_W];
    end

    assign wr_data   = elems[idx_q];
    assign wr_act    = vld_q && (state_q == ST_LOAD);
    assign frame_end = wr_act && (e_q == E_LAST);
    assign abort     = wr_act && (idx_q == I_LAST) && last_q && !frame_end;
    // A new beat may slip in behind the last element of the current one,
    // except when that element closes the frame (either normally or by an
    // early tlast) so the next frame always starts from a clean state.
    assign tready    = rdy_en_q && (state_q != ST_FULL) &&
                       (!vld_q || ((idx_q == I_LAST) && !frame_end && !abort));
    assign beat_acc  = s_axis_s2mm_tvalid && tready;
    assign rd_fire   = rd_en && (state_q == ST_FULL);

    // Element index to bank number and local address.
    always_comb begin
        is_a   = (e_q < E_MM);
        eb_off = e_q - E_MM;
        a_bank = e_q / EW'(DA);
        a_addr = AW_A'(e_q % EW'(DA));
        b_bank = eb_off / EW'(DB);
        b_addr = AW_B'(eb_off % EW'(DB));
    end

    // Next-state logic for the frame FSM, unpack register and counters.
    always_comb begin
        state_d = state_q;
        e_d     = e_q;
        buf_d   = buf_q;
        vld_d   = vld_q;
        idx_d   = idx_q;
        last_d  = last_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (wr_act) begin
            idx_d = idx_q + 1'b1;
            e_d   = e_q + 1'b1;
            if (idx_q == I_LAST) begin
                vld_d = 1'b0;
                idx_d = '0;
            end
            if (frame_end) begin
                state_d = ST_FULL;
                e_d     = '0;
                cnt_d   = cnt_q + 1'b1;
                if (!last_q) begin
                    err_d = 1'b1;
                end
            end else if (abort) begin
                state_d = ST_IDLE;
                e_d     = '0;
                err_d   = 1'b1;
            end
        end
        if (beat_acc) begin
            buf_d  = s_axis_s2mm_tdata;
            vld_d  = 1'b1;
            idx_d  = '0;
            last_d = s_axis_s2mm_tlast;
            if (state_q == ST_IDLE) begin
                state_d = ST_LOAD;
            end
        end
        if ((state_q == ST_FULL) && release_buf) begin
            state_d = ST_IDLE;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            e_q        <= '0;
            buf_q      <= '0;
            vld_q      <= 1'b0;
            idx_q      <= '0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            rdy_en_q   <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            e_q        <= e_d;
            buf_q      <= buf_d;
            vld_q      <= vld_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            rdy_en_q   <= 1'b1;
            rd_valid_q <= rd_fire;
        end
    end

    for (genvar i = 0; i < N1; i++) begin : g_a
        bank_ram #(.D_W(D_W), .DEPTH(DA)) u_ram (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .we_i    (wr_act && is_a && (a_bank == EW'(i))),
            .waddr_i (a_addr),
            .wdata_i (wr_data),
            .re_i    (rd_fire),
            .raddr_i (rd_addr_A),
            .rdata_o (A_bram[i])
        );
    end

    for (genvar i = 0; i < N2; i++) begin : g_b
        bank_ram #(.D_W(D_W), .DEPTH(DB)) u_ram (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .we_i    (wr_act && !is_a && (b_bank == EW'(i))),
            .waddr_i (b_addr),
            .wdata_i (wr_data),
            .re_i    (rd_fire),
            .raddr_i (rd_addr_B),
            .rdata_o (B_bram[i])
        );
    end

    assign s_axis_s2mm_tready = tready;
    assign full               = (state_q == ST_FULL);
    assign rd_valid           = rd_valid_q;
    assign err_tlast          = err_q;
    assign frames_loaded      = cnt_q;

endmodule
